config_commit_controller: RTL and testbench

Sequences host configuration writes into the synthesizer core's voice/operator configuration so that parameter changes take effect atomically on a sample boundary. It buffers host writes in a FIFO, drains them into the shadow configuration register file, and, once a complete transaction has been written, pulses a bank-swap on the next `SampleReady` from the core. The external config file then copies shadow to active, so no voice ever renders a sample with a half-applied patch.

---
 rtl/config_commit_controller.sv | 172 +++++++++++++++++
 tb/tb_config_commit_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_commit_controller.sv
// Host-write FIFO feeding the shadow config file, with an atomic bank swap
// issued on the first SampleReady after a complete transaction has drained.
module config_commit_controller #(
  parameter int DEPTH = 16
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_WriteValid,
  output logic        o_WriteReady,
  input  logic [3:0]  i_WriteVoice,
  input  logic [2:0]  i_WriteOperator,
  input  logic [1:0]  i_WriteField,
  input  logic [15:0] i_WriteData,
  input  logic        i_WriteLast,
  input  logic        i_SampleReady,
  output logic        o_CfgWrEn,
  output logic [3:0]  o_CfgVoice,
  output logic [2:0]  o_CfgOperator,
  output logic [1:0]  o_CfgField,
  output logic [15:0] o_CfgData,
  output logic        o_BankSwap,
  output logic        o_Busy,
  output logic [7:0]  o_SwapCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_DRAIN = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  // Entry layout: {last, voice, operator, field, data}
  logic [25:0]   r_Mem [DEPTH];
  logic [AW-1:0] r_WrPtr;
  logic [AW-1:0] r_RdPtr;
  logic [CW-1:0] r_Count;
  state_t        r_State;

  logic          r_WriteReady;
  logic          r_CfgWrEn;
  logic [3:0]    r_CfgVoice;
  logic [2:0]    r_CfgOperator;
  logic [1:0]    r_CfgField;
  logic [15:0]   r_CfgData;
  logic          r_BankSwap;
  logic          r_Busy;
  logic [7:0]    r_SwapCount;

  state_t        w_NextState;
  logic          w_Push;
  logic          w_Pop;
  logic          w_SwapReq;
  logic [25:0]   w_Head;
  logic [CW-1:0] w_NextCount;

  assign w_Push = i_WriteValid && r_WriteReady;
  assign w_Head = r_Mem[r_RdPtr];

  // Next-state logic: pop only in DRAIN, swap request only in WAIT.
  always_comb begin
    w_NextState = r_State;
    w_Pop       = 1'b0;
    w_SwapReq   = 1'b0;
    case (r_State)
      ST_DRAIN: begin
        if (r_Count != {CW{1'b0}}) begin
          w_Pop = 1'b1;
          if (w_Head[25]) begin
            w_NextState = ST_WAIT;
          end else begin
            w_NextState = ST_DRAIN;
          end
        end else begin
          w_NextState = ST_DRAIN;
        end
      end
      ST_WAIT: begin
        if (i_SampleReady) begin
          w_SwapReq   = 1'b1;
          w_NextState = ST_SWAP;
        end else begin
          w_NextState = ST_WAIT;
        end
      end
      ST_SWAP: begin
        w_NextState = ST_DRAIN;
      end
      default: begin
        w_NextState = ST_DRAIN;
      end
    endcase
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_NextCount = r_Count;
    case ({w_Push, w_Pop})
      2'b10:   w_NextCount = r_Count + CW'(1);
      2'b01:   w_NextCount = r_Count - CW'(1);
      default: w_NextCount = r_Count;
    endcase
  end

  // FIFO storage; contents are don't-care once the pointers are flushed.
  always_ff @(posedge i_Clock) begin
    if (w_Push) begin
      r_Mem[r_WrPtr] <= {i_WriteLast, i_WriteVoice, i_WriteOperator, i_WriteField, i_WriteData};
    end
  end

  // FIFO pointers, count and controller state.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_WrPtr <= {AW{1'b0}};
      r_RdPtr <= {AW{1'b0}};
      r_Count <= {CW{1'b0}};
      r_State <= ST_DRAIN;
    end else begin
      if (w_Push) begin
        r_WrPtr <= r_WrPtr + AW'(1);
      end
      if (w_Pop) begin
        r_RdPtr <= r_RdPtr + AW'(1);
      end
      r_Count <= w_NextCount;
      r_State <= w_NextState;
    end
  end

  // Registered outputs; ready and busy look ahead so they match the new count/state.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_WriteReady  <= 1'b1;
      r_CfgWrEn     <= 1'b0;
      r_CfgVoice    <= 4'd0;
      r_CfgOperator <= 3'd0;
      r_CfgField    <= 2'd0;
      r_CfgData     <= 16'd0;
      r_BankSwap    <= 1'b0;
      r_Busy        <= 1'b0;
      r_SwapCount   <= 8'd0;
    end else begin
      r_WriteReady <= (w_NextCount != CW'(DEPTH));
      r_CfgWrEn    <= w_Pop;
      if (w_Pop) begin
        r_CfgVoice    <= w_Head[24:21];
        r_CfgOperator <= w_Head[20:18];
        r_CfgField    <= w_Head[17:16];
        r_CfgData     <= w_Head[15:0];
      end
      r_BankSwap <= w_SwapReq;
      if (w_SwapReq) begin
        r_SwapCount <= r_SwapCount + 8'd1;
      end
      r_Busy <= (w_NextCount != {CW{1'b0}}) || (w_NextState != ST_DRAIN);
    end
  end

  assign o_WriteReady  = r_WriteReady;
  assign o_CfgWrEn     = r_CfgWrEn;
  assign o_CfgVoice    = r_CfgVoice;
  assign o_CfgOperator = r_CfgOperator;
  assign o_CfgField    = r_CfgField;
  assign o_CfgData     = r_CfgData;
  assign o_BankSwap    = r_BankSwap;
  assign o_Busy        = r_Busy;
  assign o_SwapCount   = r_SwapCount;

endmodule

// File: tb/tb_config_commit_controller.sv
// Directed, cycle-accurate checks of config_commit_controller (DEPTH=16).
module tb_config_commit_controller;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic        i_WriteValid;
  logic        o_WriteReady;
  logic [3:0]  i_WriteVoice;
  logic [2:0]  i_WriteOperator;
  logic [1:0]  i_WriteField;
  logic [15:0] i_WriteData;
  logic        i_WriteLast;
  logic        i_SampleReady;
  logic        o_CfgWrEn;
  logic [3:0]  o_CfgVoice;
  logic [2:0]  o_CfgOperator;
  logic [1:0]  o_CfgField;
  logic [15:0] o_CfgData;
  logic        o_BankSwap;
  logic        o_Busy;
  logic [7:0]  o_SwapCount;
  logic [24:0] cfg_obs;

  int n_checks = 0;
  int n_fail   = 0;

  config_commit_controller #(.DEPTH(16)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset),
    .i_WriteValid(i_WriteValid), .o_WriteReady(o_WriteReady),
    .i_WriteVoice(i_WriteVoice), .i_WriteOperator(i_WriteOperator),
    .i_WriteField(i_WriteField), .i_WriteData(i_WriteData),
    .i_WriteLast(i_WriteLast), .i_SampleReady(i_SampleReady),
    .o_CfgWrEn(o_CfgWrEn), .o_CfgVoice(o_CfgVoice),
    .o_CfgOperator(o_CfgOperator), .o_CfgField(o_CfgField),
    .o_CfgData(o_CfgData), .o_BankSwap(o_BankSwap),
    .o_Busy(o_Busy), .o_SwapCount(o_SwapCount)
  );

  assign cfg_obs = {o_CfgVoice, o_CfgOperator, o_CfgField, o_CfgData};

  always #5 i_Clock = ~i_Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic drive_wr(input logic [24:0] e, input logic l);
    i_WriteValid    = 1'b1;
    i_WriteVoice    = e[24:21];
    i_WriteOperator = e[20:18];
    i_WriteField    = e[17:16];
    i_WriteData     = e[15:0];
    i_WriteLast     = l;
  endtask

  task automatic idle_wr();
    i_WriteValid    = 1'b0;
    i_WriteVoice    = 4'd0;
    i_WriteOperator = 3'd0;
    i_WriteField    = 2'd0;
    i_WriteData     = 16'd0;
    i_WriteLast     = 1'b0;
  endtask

  // Leaves the bench in cycle 0 of a test: reset released, DUT idle.
  task automatic do_reset();
    idle_wr();
    i_SampleReady = 1'b0;
    i_Reset = 1'b1;
    tick();
    tick();
    i_Reset = 1'b0;
  endtask

  task automatic test_reset();
    drive_wr({4'hF, 3'd7, 2'd3, 16'hFFFF}, 1'b1);
    i_SampleReady = 1'b1;
    i_Reset = 1'b1;
    tick();
    tick();
    n_checks++; if (o_CfgWrEn !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %0b want 0", o_CfgWrEn); end
    n_checks++; if (cfg_obs !== 25'd0) begin n_fail++; $display("FAIL reset_cfg: got %h want 0", cfg_obs); end
    n_checks++; if (o_BankSwap !== 1'b0) begin n_fail++; $display("FAIL reset_swap: got %0b want 0", o_BankSwap); end
    n_checks++; if (o_SwapCount !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_SwapCount); end
    n_checks++; if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", o_Busy); end
    n_checks++; if (o_WriteReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", o_WriteReady); end
    i_Reset = 1'b0;
    i_SampleReady = 1'b0;
    idle_wr();
  endtask

  task automatic test_single();
    logic [24:0] ex [3];
    logic exp_en, exp_sw, exp_busy;
    logic [7:0] exp_cnt;
    ex[0] = {4'd2, 3'd1, 2'd0, 16'h1234};
    ex[1] = {4'd2, 3'd1, 2'd1, 16'h7FFF};
    ex[2] = {4'd2, 3'd1, 2'd2, 16'h0001};
    do_reset();
    for (int c = 0; c < 30; c++) begin
      exp_en   = (c >= 2 && c <= 4);
      exp_sw   = (c == 21);
      exp_busy = (c >= 1 && c <= 21);
      exp_cnt  = (c >= 21) ? 8'd1 : 8'd0;
      n_checks++; if (o_CfgWrEn !== exp_en) begin n_fail++; $display("FAIL single_wren c=%0d: got %0b want %0b", c, o_CfgWrEn, exp_en); end
      if (exp_en) begin
        n_checks++; if (cfg_obs !== ex[c-2]) begin n_fail++; $display("FAIL single_data c=%0d: got %h want %h", c, cfg_obs, ex[c-2]); end
      end
      n_checks++; if (o_BankSwap !== exp_sw) begin n_fail++; $display("FAIL single_swap c=%0d: got %0b want %0b", c, o_BankSwap, exp_sw); end
      n_checks++; if (o_SwapCount !== exp_cnt) begin n_fail++; $display("FAIL single_count c=%0d: got %0d want %0d", c, o_SwapCount, exp_cnt); end
      n_checks++; if (o_Busy !== exp_busy) begin n_fail++; $display("FAIL single_busy c=%0d: got %0b want %0b", c, o_Busy, exp_busy); end
      if (c < 3) drive_wr(ex[c], (c == 2)); else idle_wr();
      i_SampleReady = (c == 20);
      tick();
    end
  endtask

  task automatic test_boundary();
    logic exp_en, exp_sw;
    logic [7:0] exp_cnt;
    do_reset();
    for (int c = 0; c < 101; c++) begin
      exp_en  = (c == 2);
      exp_sw  = (c == 98);
      exp_cnt = (c >= 98) ? 8'd1 : 8'd0;
      n_checks++; if (o_CfgWrEn !== exp_en) begin n_fail++; $display("FAIL boundary_wren c=%0d: got %0b want %0b", c, o_CfgWrEn, exp_en); end
      n_checks++; if (o_BankSwap !== exp_sw) begin n_fail++; $display("FAIL boundary_swap c=%0d: got %0b want %0b", c, o_BankSwap, exp_sw); end
      n_checks++; if (o_SwapCount !== exp_cnt) begin n_fail++; $display("FAIL boundary_count c=%0d: got %0d want %0d", c, o_SwapCount, exp_cnt); end
      if (c == 0) drive_wr({4'd5, 3'd3, 2'd3, 16'h003F}, 1'b1); else idle_wr();
      i_SampleReady = (c == 1 || c == 97);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] ex [4];
    logic exp_en, exp_sw;
    int si;
    ex[0] = {4'd1, 3'd0, 2'd0, 16'h1111};
    ex[1] = {4'd1, 3'd0, 2'd1, 16'h2222};
    ex[2] = {4'd3, 3'd4, 2'd0, 16'h3333};
    ex[3] = {4'd3, 3'd4, 2'd2, 16'h0001};
    do_reset();
    for (int c = 0; c < 21; c++) begin
      si = (c == 2) ? 0 : (c == 3) ? 1 : (c == 9) ? 2 : (c == 10) ? 3 : -1;
      exp_en = (si >= 0);
      exp_sw = (c == 7 || c == 16);
      n_checks++; if (o_CfgWrEn !== exp_en) begin n_fail++; $display("FAIL b2b_wren c=%0d: got %0b want %0b", c, o_CfgWrEn, exp_en); end
      if (exp_en) begin
        n_checks++; if (cfg_obs !== ex[si]) begin n_fail++; $display("FAIL b2b_data c=%0d: got %h want %h", c, cfg_obs, ex[si]); end
      end
      n_checks++; if (o_BankSwap !== exp_sw) begin n_fail++; $display("FAIL b2b_swap c=%0d: got %0b want %0b", c, o_BankSwap, exp_sw); end
      if (c < 4) begin
        n_checks++; if (o_WriteReady !== 1'b1) begin n_fail++; $display("FAIL b2b_ready c=%0d: got %0b want 1", c, o_WriteReady); end
        drive_wr(ex[c], (c == 1 || c == 3));
      end else begin
        idle_wr();
      end
      i_SampleReady = (c == 6 || c == 15);
      tick();
    end
    n_checks++; if (o_SwapCount !== 8'd2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", o_SwapCount); end
  endtask

  task automatic test_backpressure();
    logic [24:0] first_e, extra_e, exp_e;
    logic exp_en, exp_rdy, accepted;
    logic [3:0] kk;
    int acc_cycle;
    first_e  = {4'd0, 3'd0, 2'd0, 16'hAAAA};
    extra_e  = {4'hF, 3'd7, 2'd3, 16'hBEEF};
    accepted = 1'b0;
    acc_cycle = -1;
    do_reset();
    for (int c = 0; c < 46; c++) begin
      kk = 4'(c - 23);
      exp_en = (c == 2) || (c >= 23 && c <= 39);
      exp_e  = (c == 2) ? first_e : (c == 39) ? extra_e : {kk, 3'd0, 2'd0, 16'(16'h0100 + c - 23)};
      exp_rdy = !(c >= 18 && c <= 22);
      n_checks++; if (o_WriteReady !== exp_rdy) begin n_fail++; $display("FAIL bp_ready c=%0d: got %0b want %0b", c, o_WriteReady, exp_rdy); end
      n_checks++; if (o_CfgWrEn !== exp_en) begin n_fail++; $display("FAIL bp_wren c=%0d: got %0b want %0b", c, o_CfgWrEn, exp_en); end
      if (exp_en) begin
        n_checks++; if (cfg_obs !== exp_e) begin n_fail++; $display("FAIL bp_data c=%0d: got %h want %h", c, cfg_obs, exp_e); end
      end
      if (c == 0) begin
        drive_wr(first_e, 1'b1);
      end else if (c >= 2 && c <= 17) begin
        drive_wr({4'(c - 2), 3'd0, 2'd0, 16'(16'h0100 + c - 2)}, 1'b0);
      end else if (c >= 18 && !accepted) begin
        drive_wr(extra_e, 1'b1);
        if (o_WriteReady) begin
          accepted  = 1'b1;
          acc_cycle = c;
        end
      end else begin
        idle_wr();
      end
      i_SampleReady = (c == 20);
      tick();
    end
    n_checks++; if (acc_cycle !== 23) begin n_fail++; $display("FAIL bp_accept_cycle: got %0d want 23", acc_cycle); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 26; c++) begin
      if (c >= 9) begin
        n_checks++; if (o_CfgWrEn !== 1'b0) begin n_fail++; $display("FAIL rmid_wren c=%0d: got %0b want 0", c, o_CfgWrEn); end
        n_checks++; if (o_BankSwap !== 1'b0) begin n_fail++; $display("FAIL rmid_swap c=%0d: got %0b want 0", c, o_BankSwap); end
        n_checks++; if (o_SwapCount !== 8'd0) begin n_fail++; $display("FAIL rmid_count c=%0d: got %0d want 0", c, o_SwapCount); end
        n_checks++; if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy c=%0d: got %0b want 0", c, o_Busy); end
        n_checks++; if (o_WriteReady !== 1'b1) begin n_fail++; $display("FAIL rmid_ready c=%0d: got %0b want 1", c, o_WriteReady); end
        n_checks++; if (cfg_obs !== 25'd0) begin n_fail++; $display("FAIL rmid_cfg c=%0d: got %h want 0", c, cfg_obs); end
      end else if (c == 7) begin
        n_checks++; if (o_Busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre: got %0b want 1", o_Busy); end
      end
      if (c == 0) drive_wr({4'd6, 3'd2, 2'd1, 16'h5555}, 1'b1);
      else if (c >= 2 && c <= 6) drive_wr({4'd7, 3'd1, 2'd0, 16'(16'h0010 + c)}, 1'b0);
      else idle_wr();
      i_Reset = (c == 8);
      i_SampleReady = (c == 11);
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive_wr({4'd0, 3'd0, 2'd3, 16'(i)}, 1'b1);
      tick();
      idle_wr();
      tick();
      i_SampleReady = 1'b1;
      tick();
      i_SampleReady = 1'b0;
      exp_cnt = 8'(i + 1);
      n_checks++; if (o_BankSwap !== 1'b1) begin n_fail++; $display("FAIL wrap_swap i=%0d: got %0b want 1", i, o_BankSwap); end
      n_checks++; if (o_SwapCount !== exp_cnt) begin n_fail++; $display("FAIL wrap_count i=%0d: got %0d want %0d", i, o_SwapCount, exp_cnt); end
      tick();
    end
    n_checks++; if (o_SwapCount !== 8'd0) begin n_fail++; $display("FAIL wrap_final: got %0d want 0", o_SwapCount); end
  endtask

  initial begin
    idle_wr();
    i_SampleReady = 1'b0;
    i_Reset = 1'b1;
    test_reset();
    test_single();
    test_boundary();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
